render_sequencer: RTL and testbench

- Frame-level controller behind the GPU register file.
- On a `do_render` pulse it:
  - snapshots the buffer configuration;
  - loads the colour palette from memory over the Avalon master;
  - walks every pixel in raster order, issuing one ray request per pixel to the ray/voxel traversal unit;
  - writes each resulting colour to the pixel buffer.
- Raises a sticky `irq` when the frame completes. `irq` clears on `clear_interrupt`.
- Sole owner of the m1 Avalon master port.

---
 rtl/render_sequencer_pkg.sv | 26 ++
 rtl/render_sequencer_palette_ram.sv | 27 ++
 rtl/render_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_render_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/render_sequencer_pkg.sv
// Shared types and helpers for the frame render sequencer: FSM states,
// pixel coordinate pair and the word-address helper used for both buffers.
package render_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PAL_REQ,
        PAL_WAIT,
        RAY_REQ,
        RAY_WAIT,
        PIX_WR
    } render_state_e;

    localparam logic [31:0] PIXEL_BYTES = 32'd4;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
    } pixel_coord;

    // Byte address of 32-bit word 'index' above 'base'; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] index);
        return base + index * PIXEL_BYTES;
    endfunction

endpackage

// File: rtl/render_sequencer_palette_ram.sv
// Palette storage: simple dual-port RAM, one write port and one registered
// read port, so it maps onto a single block RAM.
module palette_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/render_sequencer.sv
// Frame controller: loads the palette over m1, walks pixels in raster order
// issuing one ray each, writes the resulting colours and raises a sticky irq.
module render_sequencer
    import render_sequencer_pkg::*;
#(
    parameter logic [15:0] H_RESOLUTION  = 16'd256,
    parameter logic [15:0] V_RESOLUTION  = 16'd192,
    parameter int          PALETTE_DEPTH = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        do_render,
    input  logic        clear_interrupt,
    input  logic [31:0] pixel_buffer,
    input  logic [31:0] palette_buffer,
    input  logic [31:0] palette_length,
    output logic        ray_valid,
    output logic [15:0] ray_x,
    output logic [15:0] ray_y,
    input  logic        ray_ready,
    input  logic        hit_valid,
    input  logic        hit,
    input  logic [7:0]  hit_index,
    output logic [31:0] m1_address,
    output logic [31:0] m1_writedata,
    output logic        m1_write,
    output logic        m1_read,
    input  logic        m1_waitrequest,
    input  logic [31:0] m1_readdata,
    input  logic        m1_readdatavalid,
    output logic        busy,
    output logic        irq
);

    localparam int AW = $clog2(PALETTE_DEPTH);
    localparam int PW = AW + 1;  // wide enough to hold PALETTE_DEPTH itself

    render_state_e  state_q, state_d;
    logic [31:0]    pix_base_q, pix_base_d;
    logic [31:0]    pal_base_q, pal_base_d;
    logic [PW-1:0]  plen_q, plen_d;
    logic [PW-1:0]  p_q, p_d;
    pixel_coord     pos_q, pos_d;
    logic           colour_ok_q, colour_ok_d;
    logic           irq_q, irq_d;

    logic           ram_we, ram_re;
    logic [31:0]    ram_rd_data;
    logic [PW-1:0]  plen_clamped;
    logic           irq_set;
    logic           last_x, last_y;

    palette_ram #(.DEPTH(PALETTE_DEPTH), .AW(AW)) u_palette (
        .clock   (clock),
        .wr_en   (ram_we),
        .wr_addr (p_q[AW-1:0]),
        .wr_data (m1_readdata),
        .rd_en   (ram_re),
        .rd_addr (AW'(hit_index)),
        .rd_data (ram_rd_data)
    );

    assign plen_clamped = (palette_length > 32'(PALETTE_DEPTH)) ? PW'(PALETTE_DEPTH)
                                                                : PW'(palette_length);
    assign last_x = (pos_q.x == H_RESOLUTION - 16'd1);
    assign last_y = (pos_q.y == V_RESOLUTION - 16'd1);

    always_comb begin
        state_d      = state_q;
        pix_base_d   = pix_base_q;
        pal_base_d   = pal_base_q;
        plen_d       = plen_q;
        p_d          = p_q;
        pos_d        = pos_q;
        colour_ok_d  = colour_ok_q;
        irq_set      = 1'b0;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ray_valid    = 1'b0;
        ray_x        = 16'd0;
        ray_y        = 16'd0;
        m1_read      = 1'b0;
        m1_write     = 1'b0;
        m1_address   = 32'd0;
        m1_writedata = 32'd0;

        case (state_q)
            IDLE: begin
                if (do_render) begin
                    pix_base_d = pixel_buffer;
                    pal_base_d = palette_buffer;
                    plen_d     = plen_clamped;
                    p_d        = '0;
                    pos_d      = '0;
                    state_d    = (plen_clamped != '0) ? PAL_REQ : RAY_REQ;
                end
            end
            PAL_REQ: begin
                m1_read    = 1'b1;
                m1_address = word_addr(pal_base_q, 32'(p_q));
                if (!m1_waitrequest) begin
                    state_d = PAL_WAIT;
                end
            end
            PAL_WAIT: begin
                if (m1_readdatavalid) begin
                    ram_we  = 1'b1;
                    p_d     = p_q + PW'(1);
                    state_d = (p_q == plen_q - PW'(1)) ? RAY_REQ : PAL_REQ;
                end
            end
            RAY_REQ: begin
                ray_valid = 1'b1;
                ray_x     = pos_q.x;
                ray_y     = pos_q.y;
                if (ray_ready) begin
                    state_d = RAY_WAIT;
                end
            end
            RAY_WAIT: begin
                // The RAM output register holds the looked-up colour for the
                // whole PIX_WR phase; out-of-range or missed pixels become 0.
                if (hit_valid) begin
                    ram_re      = 1'b1;
                    colour_ok_d = hit && (32'(hit_index) < 32'(plen_q));
                    state_d     = PIX_WR;
                end
            end
            PIX_WR: begin
                m1_write     = 1'b1;
                m1_address   = word_addr(pix_base_q,
                                         32'(pos_q.y) * 32'(H_RESOLUTION) + 32'(pos_q.x));
                m1_writedata = colour_ok_q ? ram_rd_data : 32'd0;
                if (!m1_waitrequest) begin
                    if (last_x) begin
                        pos_d.x = 16'd0;
                        pos_d.y = pos_q.y + 16'd1;
                    end else begin
                        pos_d.x = pos_q.x + 16'd1;
                    end
                    if (last_x && last_y) begin
                        irq_set = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RAY_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        irq_d = irq_set | (irq_q & ~clear_interrupt);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            pix_base_q  <= 32'd0;
            pal_base_q  <= 32'd0;
            plen_q      <= '0;
            p_q         <= '0;
            pos_q       <= '0;
            colour_ok_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_base_q  <= pix_base_d;
            pal_base_q  <= pal_base_d;
            plen_q      <= plen_d;
            p_q         <= p_d;
            pos_q       <= pos_d;
            colour_ok_q <= colour_ok_d;
            irq_q       <= irq_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign irq  = irq_q;

endmodule

// File: tb/tb_render_sequencer.sv
// Randomized bench for render_sequencer: acts as Avalon slave and ray unit,
// predicting every palette read and pixel write from the frame rules.
module tb_render_sequencer;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int DEPTH = 16;
    localparam int NPIX  = H * V;

    logic        clock = 1'b0;
    logic        reset, do_render, clear_interrupt;
    logic [31:0] pixel_buffer, palette_buffer, palette_length;
    logic        ray_valid;
    logic [15:0] ray_x, ray_y;
    logic        ray_ready, hit_valid, hit;
    logic [7:0]  hit_index;
    logic [31:0] m1_address, m1_writedata, m1_readdata;
    logic        m1_write, m1_read, m1_waitrequest, m1_readdatavalid;
    logic        busy, irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] pal_mem [256];

    always #5 clock = ~clock;

    render_sequencer #(
        .H_RESOLUTION  (16'(H)),
        .V_RESOLUTION  (16'(V)),
        .PALETTE_DEPTH (DEPTH)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .do_render        (do_render),
        .clear_interrupt  (clear_interrupt),
        .pixel_buffer     (pixel_buffer),
        .palette_buffer   (palette_buffer),
        .palette_length   (palette_length),
        .ray_valid        (ray_valid),
        .ray_x            (ray_x),
        .ray_y            (ray_y),
        .ray_ready        (ray_ready),
        .hit_valid        (hit_valid),
        .hit              (hit),
        .hit_index        (hit_index),
        .m1_address       (m1_address),
        .m1_writedata     (m1_writedata),
        .m1_write         (m1_write),
        .m1_read          (m1_read),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .busy             (busy),
        .irq              (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_irq"}, 32'(irq), 32'd0);
        check_eq({tag, "_m1_read"}, 32'(m1_read), 32'd0);
        check_eq({tag, "_m1_write"}, 32'(m1_write), 32'd0);
        check_eq({tag, "_m1_address"}, m1_address, 32'd0);
        check_eq({tag, "_m1_writedata"}, m1_writedata, 32'd0);
        check_eq({tag, "_ray_valid"}, 32'(ray_valid), 32'd0);
        check_eq({tag, "_ray_x"}, 32'(ray_x), 32'd0);
        check_eq({tag, "_ray_y"}, 32'(ray_y), 32'd0);
    endtask

    // mode: 0 all hit idx 1, 1 all hit idx 0, 2 random with stray strobes,
    // 3 alternate miss / hit idx 5. wmax < 0 picks random waitrequest holds.
    task automatic run_frame(input int plen_in, input int wmax, input int mode,
                             input bit mid_start, input bit clr_last, input int rst_pix);
        logic [63:0] exp_q[$];
        logic [63:0] e;
        logic [31:0] pbase, qbase, a0, d0, rd_word, colour;
        logic [15:0] rx0, ry0;
        int plen_eff, rd_cnt, px_cnt, ray_cnt, cyc;
        int mem_hold, mem_tgt, ray_hold, ray_tgt, rd_lat, hit_lat, idx;
        bit mem_act, ray_act, last_acc, rst_now, h;

        plen_eff = (plen_in > DEPTH) ? DEPTH : plen_in;
        pbase = $urandom;
        qbase = $urandom;
        rd_cnt = 0; px_cnt = 0; ray_cnt = 0; cyc = 0;
        mem_hold = 0; mem_tgt = 0; ray_hold = 0; ray_tgt = 0; rd_lat = 0; hit_lat = 0;
        mem_act = 0; ray_act = 0; last_acc = 0; rst_now = 0;
        a0 = 0; d0 = 0; rx0 = 0; ry0 = 0; rd_word = 0;

        @(negedge clock);
        pixel_buffer    = pbase;
        palette_buffer  = qbase;
        palette_length  = 32'(plen_in);
        do_render       = 1'b1;
        clear_interrupt = 1'b1;
        @(negedge clock);
        do_render       = 1'b0;
        clear_interrupt = 1'b0;
        check_eq("busy_after_start", 32'(busy), 32'd1);
        check_eq("irq_cleared_with_start", 32'(irq), 32'd0);

        forever begin
            if (rst_now) begin
                reset = 1'b0;
                check_quiet("reset_mid_frame");
                break;
            end
            if (last_acc) begin
                check_eq("irq_after_last_write", 32'(irq), 32'd1);
                check_eq("busy_after_last_write", 32'(busy), 32'd0);
                break;
            end
            if (cyc > 20000) begin
                check_eq("frame_timeout", 32'd0, 32'd1);
                break;
            end
            cyc++;

            m1_waitrequest   = 1'b0;
            m1_readdatavalid = 1'b0;
            m1_readdata      = $urandom;
            ray_ready        = 1'b0;
            hit_valid        = 1'b0;
            hit              = 1'b0;
            hit_index        = 8'd0;
            clear_interrupt  = 1'b0;
            do_render        = 1'b0;
            pixel_buffer     = $urandom;
            palette_buffer   = $urandom;
            palette_length   = $urandom_range(0, 3);

            check_eq("rw_exclusive", 32'(m1_read & m1_write), 32'd0);

            if (rd_lat > 0) begin
                rd_lat--;
                if (rd_lat == 0) begin
                    m1_readdatavalid = 1'b1;
                    m1_readdata      = rd_word;
                end
            end

            if (hit_lat > 0) begin
                hit_lat--;
                if (hit_lat == 0) begin
                    case (mode)
                        0: begin h = 1; idx = 1; end
                        1: begin h = 1; idx = 0; end
                        3: begin h = (ray_cnt % 2) == 1; idx = 5; end
                        default: begin
                            h   = $urandom_range(0, 1) == 1;
                            idx = $urandom_range(0, plen_eff + 3);
                        end
                    endcase
                    hit_valid = 1'b1;
                    hit       = h;
                    hit_index = 8'(idx);
                    colour    = (h && idx < plen_eff) ? pal_mem[idx] : 32'd0;
                    exp_q.push_back({pbase + 32'(4 * ray_cnt), colour});
                    ray_cnt++;
                end
            end else if (mode == 2 && $urandom_range(0, 3) == 0) begin
                hit_valid = 1'b1;
                hit       = 1'b1;
                hit_index = 8'd1;
            end

            if (ray_valid) begin
                if (!ray_act) begin
                    ray_act  = 1;
                    ray_hold = 0;
                    ray_tgt  = $urandom_range(0, 2);
                    rx0 = ray_x;
                    ry0 = ray_y;
                    check_eq("ray_x", 32'(ray_x), 32'(ray_cnt % H));
                    check_eq("ray_y", 32'(ray_y), 32'(ray_cnt / H));
                end else begin
                    check_eq("ray_x_stable", 32'(ray_x), 32'(rx0));
                    check_eq("ray_y_stable", 32'(ray_y), 32'(ry0));
                end
                if (ray_hold < ray_tgt) begin
                    ray_hold++;
                end else begin
                    ray_ready = 1'b1;
                    ray_act   = 0;
                    hit_lat   = $urandom_range(1, 3);
                end
            end

            if (m1_write && !mem_act && px_cnt == rst_pix) begin
                reset   = 1'b1;
                rst_now = 1;
            end else if (m1_read || m1_write) begin
                if (!mem_act) begin
                    mem_act  = 1;
                    mem_hold = 0;
                    mem_tgt  = (wmax >= 0) ? wmax : $urandom_range(0, 3);
                    a0 = m1_address;
                    d0 = m1_writedata;
                end else begin
                    check_eq("m1_address_stable", m1_address, a0);
                    if (m1_write) check_eq("m1_writedata_stable", m1_writedata, d0);
                end
                if (mem_hold < mem_tgt) begin
                    m1_waitrequest = 1'b1;
                    mem_hold++;
                end else begin
                    mem_act = 0;
                    if (m1_write) begin
                        if (exp_q.size() == 0) begin
                            check_eq("pixel_write_expected", 32'd0, 32'd1);
                        end else begin
                            e = exp_q.pop_front();
                            check_eq("pixel_address", m1_address, e[63:32]);
                            check_eq("pixel_colour", m1_writedata, e[31:0]);
                        end
                        $display("pixel %0d addr=%h data=%h", px_cnt, m1_address, m1_writedata);
                        px_cnt++;
                        if (mid_start && px_cnt == NPIX / 2) begin
                            do_render      = 1'b1;
                            palette_length = 32'd7;
                        end
                        if (px_cnt == NPIX) begin
                            check_eq("irq_low_at_last_accept", 32'(irq), 32'd0);
                            last_acc = 1;
                            if (clr_last) clear_interrupt = 1'b1;
                        end
                    end else begin
                        check_eq("palette_read_address", m1_address, qbase + 32'(4 * rd_cnt));
                        $display("palette read %0d addr=%h", rd_cnt, m1_address);
                        rd_word = pal_mem[rd_cnt % 256];
                        rd_cnt++;
                        rd_lat = $urandom_range(1, 3);
                    end
                end
            end
            @(negedge clock);
        end

        m1_waitrequest   = 1'b0;
        m1_readdatavalid = 1'b0;
        ray_ready        = 1'b0;
        hit_valid        = 1'b0;
        clear_interrupt  = 1'b0;
        do_render        = 1'b0;
        if (rst_pix < 0) begin
            check_eq("pixel_count", 32'(px_cnt), 32'(NPIX));
            check_eq("palette_read_count", 32'(rd_cnt), 32'(plen_eff));
            check_eq("pending_pixels", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; do_render = 1'b0; clear_interrupt = 1'b0;
        pixel_buffer = 32'd0; palette_buffer = 32'd0; palette_length = 32'd0;
        ray_ready = 1'b0; hit_valid = 1'b0; hit = 1'b0; hit_index = 8'd0;
        m1_waitrequest = 1'b0; m1_readdata = 32'd0; m1_readdatavalid = 1'b0;
        for (int i = 0; i < 256; i++) pal_mem[i] = $urandom;
        pal_mem[0] = 32'h00FF_0000;
        pal_mem[1] = 32'h0000_FF00;

        repeat (3) @(negedge clock);
        check_quiet("reset");
        reset = 1'b0;

        run_frame(2,    0,  0, 0, 0, -1);
        run_frame(0,    0,  1, 0, 0, -1);
        run_frame(2,    5,  0, 0, 0, -1);
        run_frame(5,    -1, 2, 1, 1, -1);
        run_frame(2,    -1, 3, 0, 0, -1);
        run_frame(1000, -1, 2, 0, 0, -1);
        run_frame(3,    -1, 2, 0, 0, 10);
        run_frame(4,    -1, 2, 0, 0, -1);

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
